// File: rtl/pwm_pkg.sv
// Shared widths, reset constants and types for the multi-channel PWM block.
// PWM_FADE_EN selects stepped (fading) duty updates instead of direct copies.
package pwm_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_SIZE   = 13;
  localparam int DEF_DIV_W  = 8;

  typedef logic [DEF_SIZE-1:0] duty_t;

  // The reset period is "all ones" at whatever counter width the top is built with.
  function automatic logic [63:0] allOnes(input int w);
    allOnes = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) allOnes[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair, pending flag and registered output.
// With PWM_FADE_EN defined the active duty steps one LSB per boundary.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [SIZE-1:0] duty_i,
  input  logic            boundary_i,
  input  logic [SIZE-1:0] cnt_i,
  input  logic            en_i,
  output logic            pwm_o,
  output logic            updPend_o
);

  logic [SIZE-1:0] shadow_q, shadow_d;
  logic [SIZE-1:0] active_q, active_d;
  logic            pend_q, pend_d;
  logic            pwm_q, pwm_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    pwm_d    = en_i && (cnt_i < active_q);

    // The boundary consumes the old shadow; a same-clock load lands afterwards.
    if (boundary_i) begin
`ifdef PWM_FADE_EN
      if (active_q < shadow_q) begin
        active_d = active_q + 1'b1;
      end else if (active_q > shadow_q) begin
        active_d = active_q - 1'b1;
      end
      pend_d = (active_d != shadow_q);
`else
      active_d = shadow_q;
      pend_d   = 1'b0;
`endif
    end

    if (load_i) begin
      shadow_d = duty_i;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign updPend_o = pend_q;

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM top: shared prescaler, period counter and shadow/active period.
// Build with PWM_FADE_EN defined to make duty updates fade one LSB per period.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SIZE   = DEF_SIZE,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div,
  input  logic [SIZE-1:0]   period,
  input  logic              period_ld,
  input  logic [SIZE-1:0]   duty,
  input  logic [NUM_CH-1:0] load,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pwm,
  output logic [NUM_CH-1:0] upd_pend,
  output logic              wrap
);

  localparam logic [SIZE-1:0] RST_PERIOD = SIZE'(allOnes(SIZE));

  logic [DIV_W-1:0] preCnt_q, preCnt_d;
  logic [SIZE-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]  shadowPeriod_q, shadowPeriod_d;
  logic [SIZE-1:0]  activePeriod_q, activePeriod_d;
  logic             wrap_q, wrap_d;
  logic             tick, boundary;

  // The prescaler is never cleared on a div change, so a shrinking div may
  // let preCnt run past it and roll over before the next tick.
  always_comb begin
    tick           = (preCnt_q == div);
    boundary       = tick && (cnt_q == activePeriod_q);
    preCnt_d       = tick ? '0 : preCnt_q + 1'b1;
    cnt_d          = cnt_q;
    if (tick) begin
      cnt_d = boundary ? '0 : cnt_q + 1'b1;
    end
    shadowPeriod_d = period_ld ? period : shadowPeriod_q;
    activePeriod_d = boundary ? shadowPeriod_q : activePeriod_q;
    wrap_d         = boundary;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      preCnt_q       <= '0;
      cnt_q          <= '0;
      shadowPeriod_q <= RST_PERIOD;
      activePeriod_q <= RST_PERIOD;
      wrap_q         <= 1'b0;
    end else begin
      preCnt_q       <= preCnt_d;
      cnt_q          <= cnt_d;
      shadowPeriod_q <= shadowPeriod_d;
      activePeriod_q <= activePeriod_d;
      wrap_q         <= wrap_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    pwm_channel #(
      .SIZE(SIZE)
    ) u_ch (
      .clk_i     (sys_clk),
      .rst_ni    (rst),
      .load_i    (load[g]),
      .duty_i    (duty),
      .boundary_i(boundary),
      .cnt_i     (cnt_q),
      .en_i      (ch_en[g]),
      .pwm_o     (pwm[g]),
      .updPend_o (upd_pend[g])
    );
  end

  assign wrap = wrap_q;

endmodule
